div_nonrestoring_seq: RTL and testbench

Front-end sequencer for the 8-bit non-restoring divider. It accepts a 16-bit dividend / 8-bit divisor request over a valid/ready handshake and screens out divide-by-zero and quotient overflow. It then serialises operands onto the divider's shared byte bus (enable pulse, A, Q, M), collects quotient and remainder from the divider's two-cycle result burst, and returns them with a status code over a second valid/ready handshake. It sits directly upstream of `div_nonrestoring` and is its only bus master.

---
 rtl/div_pkg.sv | 26 ++
 rtl/div_nonrestoring_seq.sv | 214 +++++++++++++++++++++
 tb/tb_div_nonrestoring_seq.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types for the non-restoring divider front-end sequencer.
package div_pkg;

    localparam int W_DEFAULT = 8;

    // Sequencer states, in the order a normal transaction walks through them.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_A    = 3'd1,
        S_HOLD_A    = 3'd2,
        S_LOAD_Q    = 3'd3,
        S_LOAD_M    = 3'd4,
        S_WAIT_DONE = 3'd5,
        S_READ_R    = 3'd6,
        S_RESP      = 3'd7
    } seq_state_t;

    // Response status codes as seen on rsp_status.
    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_DIV0     = 2'b01,
        ST_OVERFLOW = 2'b10,
        ST_TIMEOUT  = 2'b11
    } div_status_t;

endpackage

// File: rtl/div_nonrestoring_seq.sv
// Front-end sequencer for the 8-bit non-restoring divider: screens requests,
// serialises A/Q/M onto the divider byte bus, collects the two-cycle result
// burst and returns quotient/remainder/status. Every output is a register
// loaded from the decode of the state being entered.
module div_nonrestoring_seq
    import div_pkg::*;
#(
    parameter int W              = W_DEFAULT,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [2*W-1:0] req_dividend,
    input  logic [W-1:0]   req_divisor,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [W-1:0]   rsp_quotient,
    output logic [W-1:0]   rsp_remainder,
    output logic [1:0]     rsp_status,
    output logic           div_enable,
    output logic [W-1:0]   div_inbus,
    input  logic           div_done,
    input  logic [W-1:0]   div_outbus
);

    localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    // State and operand/result holding registers
    seq_state_t     r_state;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_q;
    logic [W-1:0]   r_m;
    logic [W-1:0]   r_quot;
    logic [CW-1:0]  r_cnt;

    // Output registers
    logic           r_req_ready;
    logic           r_rsp_valid;
    logic [W-1:0]   r_rsp_quotient;
    logic [W-1:0]   r_rsp_remainder;
    div_status_t    r_rsp_status;
    logic           r_div_enable;
    logic [W-1:0]   r_div_inbus;

    // Next-state and next-data values
    seq_state_t     w_state_next;
    logic [W-1:0]   w_a_next;
    logic [W-1:0]   w_q_next;
    logic [W-1:0]   w_m_next;
    logic [W-1:0]   w_quot_next;
    logic [CW-1:0]  w_cnt_next;
    logic [W-1:0]   w_res_quotient;
    logic [W-1:0]   w_res_remainder;
    div_status_t    w_res_status;

    // Next values of the output registers
    logic           w_req_ready_next;
    logic           w_rsp_valid_next;
    logic [W-1:0]   w_rsp_quotient_next;
    logic [W-1:0]   w_rsp_remainder_next;
    div_status_t    w_rsp_status_next;
    logic           w_div_enable_next;
    logic [W-1:0]   w_div_inbus_next;

    logic           w_req_fire;
    logic           w_rsp_fire;

    // Handshakes are qualified by the registered ready/valid we actually drive.
    assign w_req_fire = (r_state == S_IDLE) && r_req_ready && req_valid;
    assign w_rsp_fire = (r_state == S_RESP) && r_rsp_valid && rsp_ready;

    // Next-state, operand capture, timeout counting and result selection.
    always_comb begin
        w_state_next    = r_state;
        w_a_next        = r_a;
        w_q_next        = r_q;
        w_m_next        = r_m;
        w_quot_next     = r_quot;
        w_cnt_next      = r_cnt;
        w_res_quotient  = r_rsp_quotient;
        w_res_remainder = r_rsp_remainder;
        w_res_status    = r_rsp_status;

        case (r_state)
            S_IDLE: begin
                if (w_req_fire) begin
                    w_a_next = req_dividend[2*W-1:W];
                    w_q_next = req_dividend[W-1:0];
                    w_m_next = req_divisor;
                    if (req_divisor == '0) begin
                        w_state_next    = S_RESP;
                        w_res_status    = ST_DIV0;
                        w_res_quotient  = '1;
                        w_res_remainder = req_dividend[W-1:0];
                    end else if (req_dividend[2*W-1:W] >= req_divisor) begin
                        // Quotient would not fit in W bits.
                        w_state_next    = S_RESP;
                        w_res_status    = ST_OVERFLOW;
                        w_res_quotient  = '0;
                        w_res_remainder = '0;
                    end else begin
                        w_state_next = S_LOAD_A;
                    end
                end
            end
            S_LOAD_A: w_state_next = S_HOLD_A;
            S_HOLD_A: w_state_next = S_LOAD_Q;
            S_LOAD_Q: w_state_next = S_LOAD_M;
            S_LOAD_M: begin
                w_cnt_next   = '0;
                w_state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                w_cnt_next = r_cnt + CW'(1);
                // A result strobe on the last allowed cycle still counts.
                if (div_done) begin
                    w_quot_next  = div_outbus;
                    w_state_next = S_READ_R;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next    = S_RESP;
                    w_res_status    = ST_TIMEOUT;
                    w_res_quotient  = '0;
                    w_res_remainder = '0;
                end
            end
            S_READ_R: begin
                w_state_next    = S_RESP;
                w_res_status    = ST_OK;
                w_res_quotient  = r_quot;
                w_res_remainder = div_outbus;
            end
            S_RESP: begin
                if (w_rsp_fire) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output decode for the state being entered, so outputs come straight from flops.
    always_comb begin
        w_req_ready_next     = 1'b0;
        w_rsp_valid_next     = 1'b0;
        w_rsp_quotient_next  = '0;
        w_rsp_remainder_next = '0;
        w_rsp_status_next    = ST_OK;
        w_div_enable_next    = 1'b0;
        w_div_inbus_next     = '0;

        case (w_state_next)
            S_IDLE:   w_req_ready_next = 1'b1;
            S_LOAD_A: begin
                w_div_enable_next = 1'b1;
                w_div_inbus_next  = w_a_next;
            end
            S_HOLD_A: w_div_inbus_next = w_a_next;
            S_LOAD_Q: w_div_inbus_next = w_q_next;
            S_LOAD_M: w_div_inbus_next = w_m_next;
            S_RESP: begin
                w_rsp_valid_next     = 1'b1;
                w_rsp_quotient_next  = w_res_quotient;
                w_rsp_remainder_next = w_res_remainder;
                w_rsp_status_next    = w_res_status;
            end
            default: ;
        endcase
    end

    // State, data and output registers; reset drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_a             <= '0;
            r_q             <= '0;
            r_m             <= '0;
            r_quot          <= '0;
            r_cnt           <= '0;
            r_req_ready     <= 1'b0;
            r_rsp_valid     <= 1'b0;
            r_rsp_quotient  <= '0;
            r_rsp_remainder <= '0;
            r_rsp_status    <= ST_OK;
            r_div_enable    <= 1'b0;
            r_div_inbus     <= '0;
        end else begin
            r_state         <= w_state_next;
            r_a             <= w_a_next;
            r_q             <= w_q_next;
            r_m             <= w_m_next;
            r_quot          <= w_quot_next;
            r_cnt           <= w_cnt_next;
            r_req_ready     <= w_req_ready_next;
            r_rsp_valid     <= w_rsp_valid_next;
            r_rsp_quotient  <= w_rsp_quotient_next;
            r_rsp_remainder <= w_rsp_remainder_next;
            r_rsp_status    <= w_rsp_status_next;
            r_div_enable    <= w_div_enable_next;
            r_div_inbus     <= w_div_inbus_next;
        end
    end

    assign req_ready     = r_req_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_quotient  = r_rsp_quotient;
    assign rsp_remainder = r_rsp_remainder;
    assign rsp_status    = r_rsp_status;
    assign div_enable    = r_div_enable;
    assign div_inbus     = r_div_inbus;

endmodule

// File: tb/tb_div_nonrestoring_seq.sv
// Self-checking bench for div_nonrestoring_seq with a behavioural divider
// responder and an arithmetic reference model of the full request/response.
module tb_div_nonrestoring_seq;

    localparam int W = 8;
    localparam int T = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [15:0]  req_dividend;
    logic [7:0]   req_divisor;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [7:0]   rsp_quotient;
    logic [7:0]   rsp_remainder;
    logic [1:0]   rsp_status;
    logic         div_enable;
    logic [7:0]   div_inbus;
    logic         div_done;
    logic [7:0]   div_outbus;

    int tests_run    = 0;
    int tests_failed = 0;

    // Divider model controls and observations
    bit         div_respond = 1'b1;
    int         div_latency = 1;
    int         m_starts    = 0;
    logic [7:0] m_a, m_hold, m_q, m_m;
    logic       m_en2;

    div_nonrestoring_seq #(.W(W), .TIMEOUT_CYCLES(T)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_status    (rsp_status),
        .div_enable    (div_enable),
        .div_inbus     (div_inbus),
        .div_done      (div_done),
        .div_outbus    (div_outbus)
    );

    always #5 clk = ~clk;

    // Behavioural divider: records the operand bytes, then after div_latency
    // cycles returns quotient and remainder on consecutive cycles.
    initial begin : div_model
        logic [15:0] dd;
        div_done   = 1'b0;
        div_outbus = '0;
        forever begin
            @(negedge clk);
            if (div_enable === 1'b1 && rst === 1'b0) begin
                m_starts++;
                m_a = div_inbus;
                @(negedge clk); m_hold = div_inbus; m_en2 = div_enable;
                @(negedge clk); m_q = div_inbus;
                @(negedge clk); m_m = div_inbus;
                if (div_respond) begin
                    dd = {m_a, m_q};
                    repeat (div_latency) @(negedge clk);
                    div_done   = 1'b1;
                    div_outbus = (m_m == 0) ? 8'h00 : 8'(dd / m_m);
                    @(negedge clk);
                    div_done   = 1'b0;
                    div_outbus = (m_m == 0) ? 8'h00 : 8'(dd % m_m);
                    @(negedge clk);
                    div_outbus = 8'($urandom);
                end
            end
        end
    end

    // Reference: what the whole sequencer+divider pair should return.
    function automatic void ref_div(input logic [15:0] dvd, input logic [7:0] dvs,
                                    output logic [1:0] st, output logic [7:0] q,
                                    output logic [7:0] r);
        if (dvs == 0) begin
            st = 2'b01; q = 8'hFF; r = dvd[7:0];
        end else if ((dvd / dvs) > 255) begin
            st = 2'b10; q = 8'h00; r = 8'h00;
        end else begin
            st = 2'b00; q = 8'(dvd / dvs); r = 8'(dvd % dvs);
        end
    endfunction

    // Presents a request and returns at the cycle-1 negedge after the handshake.
    task automatic send_req(input logic [15:0] dvd, input logic [7:0] dvs);
        int n;
        n = 0;
        req_valid = 1'b1; req_dividend = dvd; req_divisor = dvs;
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests_run++; tests_failed++;
            $display("FAIL req_ready_wait: req_ready=%b after %0d cycles, required 1", req_ready, n);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_dividend = 16'($urandom); req_divisor = 8'($urandom);
    endtask

    // Starting at cycle 1, returns the cycle number in which rsp_valid is seen.
    task automatic wait_rsp(output int cyc);
        cyc = 1;
        while (rsp_valid !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        if (rsp_valid !== 1'b1) begin
            tests_run++; tests_failed++;
            $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, required 1", rsp_valid, cyc);
        end
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [29:0] outs;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        outs = {req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_status, div_enable, div_inbus};
        tests_run++;
        if (outs !== '0) begin tests_failed++; $display("FAIL reset_outputs: got %h required 0", outs); end
        rst = 1'b0;
        tests_run++;
        if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready_early: got %b required 0", req_ready); end
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready_rise: got %b required 1", req_ready); end
        $display("[TB] reset: done");
    endtask

    task automatic test_basic();
        int cyc, s0;
        s0 = m_starts;
        div_latency = 3;
        send_req(16'h007F, 8'h19);
        wait_rsp(cyc);
        tests_run++; if (cyc != 9) begin tests_failed++; $display("FAIL basic_latency: got %0d required 9", cyc); end
        tests_run++; if (m_starts - s0 != 1) begin tests_failed++; $display("FAIL basic_starts: got %0d required 1", m_starts - s0); end
        tests_run++; if ({m_a, m_hold, m_en2} !== {8'h00, 8'h00, 1'b0}) begin tests_failed++; $display("FAIL basic_bus_a: got a=%h hold=%h en2=%b required 00 00 0", m_a, m_hold, m_en2); end
        tests_run++; if ({m_q, m_m} !== 16'h7F19) begin tests_failed++; $display("FAIL basic_bus_qm: got %h %h required 7f 19", m_q, m_m); end
        tests_run++; if (rsp_status !== 2'b00) begin tests_failed++; $display("FAIL basic_status: got %b required 00", rsp_status); end
        tests_run++; if (rsp_quotient !== 8'h05) begin tests_failed++; $display("FAIL basic_q: got %h required 05", rsp_quotient); end
        tests_run++; if (rsp_remainder !== 8'h02) begin tests_failed++; $display("FAIL basic_r: got %h required 02", rsp_remainder); end
        take_rsp();
        $display("[TB] basic: 007f/19 -> q=%h r=%h st=%b cyc=%0d", 8'h05, 8'h02, 2'b00, cyc);
    endtask

    task automatic test_div0();
        int cyc, s0;
        s0 = m_starts;
        send_req(16'h1234, 8'h00);
        wait_rsp(cyc);
        tests_run++; if (cyc != 1) begin tests_failed++; $display("FAIL div0_latency: got %0d required 1", cyc); end
        tests_run++; if ({rsp_status, rsp_quotient, rsp_remainder} !== {2'b01, 8'hFF, 8'h34}) begin tests_failed++; $display("FAIL div0_result: got st=%b q=%h r=%h required 01 ff 34", rsp_status, rsp_quotient, rsp_remainder); end
        take_rsp();
        repeat (2) @(negedge clk);
        tests_run++; if (m_starts != s0) begin tests_failed++; $display("FAIL div0_no_enable: got %0d starts required 0", m_starts - s0); end
        $display("[TB] div0: 1234/00 -> st=01 cyc=%0d", cyc);
    endtask

    task automatic test_overflow();
        int cyc, s0;
        s0 = m_starts;
        send_req(16'h0100, 8'h01);
        wait_rsp(cyc);
        tests_run++; if (cyc != 1) begin tests_failed++; $display("FAIL ovf_latency: got %0d required 1", cyc); end
        tests_run++; if ({rsp_status, rsp_quotient, rsp_remainder} !== {2'b10, 8'h00, 8'h00}) begin tests_failed++; $display("FAIL ovf_result: got st=%b q=%h r=%h required 10 00 00", rsp_status, rsp_quotient, rsp_remainder); end
        take_rsp();
        repeat (2) @(negedge clk);
        tests_run++; if (m_starts != s0) begin tests_failed++; $display("FAIL ovf_no_enable: got %0d starts required 0", m_starts - s0); end
        $display("[TB] overflow: 0100/01 -> st=10 cyc=%0d", cyc);
    endtask

    task automatic test_timeout();
        int cyc;
        div_respond = 1'b0;
        send_req(16'h0042, 8'h10);
        wait_rsp(cyc);
        tests_run++; if (cyc != 5 + T) begin tests_failed++; $display("FAIL tmo_latency: got %0d required %0d", cyc, 5 + T); end
        tests_run++; if ({rsp_status, rsp_quotient, rsp_remainder} !== {2'b11, 8'h00, 8'h00}) begin tests_failed++; $display("FAIL tmo_result: got st=%b q=%h r=%h required 11 00 00", rsp_status, rsp_quotient, rsp_remainder); end
        take_rsp();
        $display("[TB] timeout: 0042/10 -> st=11 cyc=%0d", cyc);
        div_respond = 1'b1;
        div_latency = 2;
        send_req(16'h0A00, 8'h20);
        wait_rsp(cyc);
        tests_run++; if (cyc != 8) begin tests_failed++; $display("FAIL tmo_next_latency: got %0d required 8", cyc); end
        tests_run++; if ({rsp_status, rsp_quotient, rsp_remainder} !== {2'b00, 8'h50, 8'h00}) begin tests_failed++; $display("FAIL tmo_next_result: got st=%b q=%h r=%h required 00 50 00", rsp_status, rsp_quotient, rsp_remainder); end
        take_rsp();
        $display("[TB] after timeout: 0a00/20 -> st=00 cyc=%0d", cyc);
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [1:0] es;
        logic [7:0] eq, er;
        div_latency = 1;
        ref_div(16'h00C8, 8'h07, es, eq, er);
        send_req(16'h00C8, 8'h07);
        wait_rsp(cyc);
        tests_run++; if (cyc != 7) begin tests_failed++; $display("FAIL bp_latency: got %0d required 7", cyc); end
        req_valid = 1'b1; req_dividend = 16'h0033; req_divisor = 8'h05;
        rsp_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests_run++;
            if ({rsp_valid, rsp_status, rsp_quotient, rsp_remainder} !== {1'b1, es, eq, er}) begin
                tests_failed++;
                $display("FAIL bp_hold%0d: got v=%b st=%b q=%h r=%h required 1 %b %h %h", i, rsp_valid, rsp_status, rsp_quotient, rsp_remainder, es, eq, er);
            end
            tests_run++;
            if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_ready%0d: got %b required 0", i, req_ready); end
        end
        take_rsp();
        tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_accept_ready: got %b required 1", req_ready); end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        tests_run++; if ({div_enable, div_inbus} !== {1'b1, 8'h00}) begin tests_failed++; $display("FAIL bp_accept_load: got en=%b bus=%h required 1 00", div_enable, div_inbus); end
        ref_div(16'h0033, 8'h05, es, eq, er);
        wait_rsp(cyc);
        tests_run++; if ({rsp_status, rsp_quotient, rsp_remainder} !== {es, eq, er}) begin tests_failed++; $display("FAIL bp_second: got st=%b q=%h r=%h required %b %h %h", rsp_status, rsp_quotient, rsp_remainder, es, eq, er); end
        take_rsp();
        $display("[TB] backpressure: 10 held cycles, follow-up 0033/05 -> q=%h r=%h", eq, er);
    endtask

    task automatic test_reset_mid();
        logic [29:0] outs;
        bit seen;
        div_respond = 1'b0;
        send_req(16'h0010, 8'h20);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        outs = {req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_status, div_enable, div_inbus};
        tests_run++; if (outs !== '0) begin tests_failed++; $display("FAIL rstmid_outputs: got %h required 0", outs); end
        rst = 1'b0;
        @(negedge clk);
        tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_ready: got %b required 1", req_ready); end
        seen = 1'b0;
        repeat (6) begin
            if (rsp_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL rstmid_no_rsp: got response=%b required 0", seen); end
        div_respond = 1'b1;
        $display("[TB] reset mid-operation: transaction dropped");
    endtask

    task automatic test_random_back_to_back();
        int cyc, lat, hold, mode, dvs_i, exp_cyc;
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [1:0]  es;
        logic [7:0]  eq, er;
        for (int k = 0; k < 24; k++) begin
            mode  = $urandom_range(0, 7);
            dvs_i = $urandom_range(1, 255);
            if (mode == 0) begin
                dvs = 8'h00;
                dvd = 16'($urandom);
            end else if (mode == 1) begin
                dvs = 8'(dvs_i);
                dvd = {8'($urandom_range(dvs_i, 255)), 8'($urandom)};
            end else begin
                dvs = 8'(dvs_i);
                dvd = {8'($urandom_range(0, dvs_i - 1)), 8'($urandom)};
            end
            lat = $urandom_range(1, 6);
            div_latency = lat;
            ref_div(dvd, dvs, es, eq, er);
            exp_cyc = (es == 2'b00) ? 6 + lat : 1;
            send_req(dvd, dvs);
            wait_rsp(cyc);
            tests_run++;
            if (cyc != exp_cyc) begin tests_failed++; $display("FAIL rnd%0d_latency: got %0d required %0d", k, cyc, exp_cyc); end
            tests_run++;
            if ({rsp_status, rsp_quotient, rsp_remainder} !== {es, eq, er}) begin
                tests_failed++;
                $display("FAIL rnd%0d_result: %h/%h got st=%b q=%h r=%h required %b %h %h", k, dvd, dvs, rsp_status, rsp_quotient, rsp_remainder, es, eq, er);
            end
            hold = $urandom_range(0, 3);
            repeat (hold) @(negedge clk);
            take_rsp();
            tests_run++;
            if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL rnd%0d_ready_after: got %b required 1", k, req_ready); end
            $display("[TB] rnd %0d: %h/%h -> st=%b q=%h r=%h cyc=%0d", k, dvd, dvs, es, eq, er, cyc);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_dividend = '0; req_divisor = '0; rsp_ready = 1'b0;
        test_reset();
        test_basic();
        test_div0();
        test_overflow();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_random_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
